instruction_fetch_queue: RTL and testbench

Fetch stage that drives the program counter into the instruction memory and buffers the returned words for the decode stage. The instruction memory read is combinational, so this block owns all fetch sequencing. It holds a sequential fetch PC, captures {pc, instruction} pairs into a small FIFO and presents them to decode through a valid/ready handshake. Redirects from branch, jump, trap or mret resolution flush the FIFO.

---
 rtl/instruction_fetch_queue_if.sv | 29 ++
 rtl/instruction_fetch_queue.sv | 113 +++++++++++
 tb/tb_instruction_fetch_queue.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_queue_if.sv
// Fetch-to-decode bundle: imem address/data, redirect request and the decode-side queue head.
// master = fetch queue side, slave = environment (imem + decode + redirect source).
`timescale 1ns/1ps
interface instruction_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   imem_pc;
  logic [31:0]   imem_instruction;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instruction;
  logic          out_misaligned;
  logic [CW-1:0] count;

  modport master (
    output imem_pc, out_valid, out_pc, out_instruction, out_misaligned, count,
    input  imem_instruction, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_pc, out_valid, out_pc, out_instruction, out_misaligned, count,
    output imem_instruction, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Sequential fetch PC + DEPTH-entry {pc, instr} queue; fetch-to-output latency 1 cycle, redirect flushes.
// Backpressure: out_ready=0 fills the queue, then fetch stalls (full + pop still fetches).
`timescale 1ns/1ps
module instruction_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic                        clk,
  input  logic                        reset_n,
  instruction_fetch_queue_if.master   fq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } entry_t;

  typedef enum logic {
    S_FETCH,
    S_HALTED
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [AW-1:0] rd_ptr, rd_ptr_nxt;
  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic [AW:0] cnt, cnt_nxt;
  entry_t      mem [DEPTH];
  entry_t      wr_entry;
  entry_t      head;

  logic        pc_misaligned;
  logic        push;
  logic        pop;

  assign pc_misaligned = |fetch_pc[1:0];

  // Pop depends only on registered occupancy, so out_ready never reaches out_valid.
  assign pop  = (cnt != '0) & fq.out_ready & ~fq.redirect;
  assign push = ~fq.redirect & (state == S_FETCH) & ((cnt < FULL_CNT) | pop);

  always_comb begin
    wr_entry            = '0;
    wr_entry.pc         = fetch_pc;
    wr_entry.misaligned = pc_misaligned;
    wr_entry.instr      = pc_misaligned ? NOP_WORD : fq.imem_instruction;
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    rd_ptr_nxt   = rd_ptr;
    wr_ptr_nxt   = wr_ptr;
    cnt_nxt      = cnt;
    if (fq.redirect) begin
      state_nxt    = S_FETCH;
      fetch_pc_nxt = fq.redirect_pc;
      rd_ptr_nxt   = '0;
      wr_ptr_nxt   = '0;
      cnt_nxt      = '0;
    end else begin
      if (push) begin
        wr_ptr_nxt = wr_ptr + 1'b1;
        // A misaligned target leaves one fault marker and parks fetch until redirected.
        if (pc_misaligned) begin
          state_nxt = S_HALTED;
        end else begin
          fetch_pc_nxt = fetch_pc + 32'd4;
        end
      end
      if (pop) begin
        rd_ptr_nxt = rd_ptr + 1'b1;
      end
      cnt_nxt = cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_FETCH;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      rd_ptr   <= rd_ptr_nxt;
      wr_ptr   <= wr_ptr_nxt;
      cnt      <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  assign head               = mem[rd_ptr];
  assign fq.imem_pc         = fetch_pc;
  assign fq.out_valid       = (cnt != '0);
  assign fq.out_pc          = head.pc;
  assign fq.out_instruction = head.instr;
  assign fq.out_misaligned  = head.misaligned;
  assign fq.count           = cnt;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_instruction_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  ent_t        mq[$];
  logic [31:0] m_pc = RESET_PC;
  bit          m_halted = 1'b0;

  instruction_fetch_queue_if #(.DEPTH(DEPTH)) fq();

  instruction_fetch_queue #(
    .DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .fq(fq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {2'b00, a[31:2]};
  endfunction

  assign fq.imem_instruction = imem_word(fq.imem_pc);

  // Advance the reference model by the edge about to happen, then step past it.
  task automatic tick();
    bit pop;
    bit push;
    ent_t e;
    if (!reset_n) begin
      mq.delete(); m_pc = RESET_PC; m_halted = 1'b0;
    end else if (fq.redirect) begin
      mq.delete(); m_pc = fq.redirect_pc; m_halted = 1'b0;
    end else begin
      pop  = (mq.size() != 0) && fq.out_ready;
      push = !m_halted && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc = m_pc;
        if (m_pc[1:0] == 2'b00) begin
          e.instr = imem_word(m_pc); e.mis = 1'b0; m_pc = m_pc + 32'd4;
        end else begin
          e.instr = NOP; e.mis = 1'b1; m_halted = 1'b1;
        end
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; fq.redirect = 1'b0; fq.redirect_pc = '0; fq.out_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fq.redirect = ($urandom_range(0, 1) == 1);
      fq.redirect_pc = $urandom;
      fq.out_ready = ($urandom_range(0, 1) == 1);
      tick();
      n_tests++;
      if (fq.out_valid !== 1'b0 || fq.count !== 3'd0 || fq.imem_pc !== RESET_PC) begin
        n_fail++;
        $display("FAIL reset_state: valid=%b count=%0d imem_pc=%h, expected 0/0/%h",
                 fq.out_valid, fq.count, fq.imem_pc, RESET_PC);
      end
    end
    reset_n = 1'b1; fq.redirect = 1'b0; fq.out_ready = 1'b0;
    tick();
    n_tests++;
    if (fq.out_valid !== 1'b1 || fq.out_pc !== RESET_PC || fq.count !== 3'd1 ||
        fq.out_instruction !== imem_word(RESET_PC)) begin
      n_fail++;
      $display("FAIL reset_release: valid=%b pc=%h instr=%h count=%0d, expected 1/%h/%h/1",
               fq.out_valid, fq.out_pc, fq.out_instruction, fq.count, RESET_PC, imem_word(RESET_PC));
    end
  endtask

  task automatic test_stream();
    do_reset();
    fq.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_tests++;
      if (fq.out_valid !== 1'b1 || fq.count !== 3'd1 || fq.out_pc !== 32'(4 * i) ||
          fq.out_instruction !== imem_word(32'(4 * i)) || fq.out_misaligned !== 1'b0) begin
        n_fail++;
        $display("FAIL stream[%0d]: valid=%b count=%0d pc=%h instr=%h, expected 1/1/%h/%h",
                 i, fq.out_valid, fq.count, fq.out_pc, fq.out_instruction, 32'(4 * i), imem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset();
    fq.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (fq.count !== 3'((i + 1 > DEPTH) ? DEPTH : i + 1) || fq.out_pc !== 32'h0 || fq.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure_fill[%0d]: count=%0d pc=%h, expected %0d/0", i, fq.count, fq.out_pc,
                 (i + 1 > DEPTH) ? DEPTH : i + 1);
      end
    end
    n_tests++;
    if (fq.imem_pc !== 32'h10) begin
      n_fail++;
      $display("FAIL backpressure_hold: imem_pc=%h expected 00000010", fq.imem_pc);
    end
    fq.out_ready = 1'b1;
    tick();
    fq.out_ready = 1'b0;
    n_tests++;
    if (fq.count !== 3'd4 || fq.out_pc !== 32'h4 || fq.imem_pc !== 32'h14) begin
      n_fail++;
      $display("FAIL full_plus_pop: count=%0d pc=%h imem_pc=%h, expected 4/4/14", fq.count, fq.out_pc, fq.imem_pc);
    end
    tick();
    n_tests++;
    if (fq.count !== 3'd4 || fq.out_pc !== 32'h4) begin
      n_fail++;
      $display("FAIL head_stable: count=%0d pc=%h, expected 4/4", fq.count, fq.out_pc);
    end
    fq.out_ready = 1'b1;
    exp_pc = 32'h8;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (fq.out_valid !== 1'b1 || fq.out_pc !== exp_pc || fq.out_instruction !== imem_word(exp_pc)) begin
        n_fail++;
        $display("FAIL drain[%0d]: valid=%b pc=%h, expected 1/%h", i, fq.out_valid, fq.out_pc, exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    fq.out_ready = 1'b0;
    tick(); tick(); tick();
    n_tests++;
    if (fq.count !== 3'd3) begin
      n_fail++;
      $display("FAIL flush_setup: count=%0d expected 3", fq.count);
    end
    fq.redirect = 1'b1; fq.redirect_pc = 32'h1000; fq.out_ready = 1'b1;
    tick();
    fq.redirect = 1'b0;
    n_tests++;
    if (fq.out_valid !== 1'b0 || fq.imem_pc !== 32'h1000 || fq.count !== 3'd0) begin
      n_fail++;
      $display("FAIL flush: valid=%b imem_pc=%h count=%0d, expected 0/1000/0", fq.out_valid, fq.imem_pc, fq.count);
    end
    tick();
    n_tests++;
    if (fq.out_valid !== 1'b1 || fq.out_pc !== 32'h1000 || fq.out_instruction !== imem_word(32'h1000) ||
        fq.out_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_target: valid=%b pc=%h instr=%h, expected 1/1000/%h",
               fq.out_valid, fq.out_pc, fq.out_instruction, imem_word(32'h1000));
    end
  endtask

  task automatic test_misaligned();
    fq.out_ready = 1'b1;
    fq.redirect = 1'b1; fq.redirect_pc = 32'h79;
    tick();
    fq.redirect = 1'b0;
    n_tests++;
    if (fq.out_valid !== 1'b0 || fq.imem_pc !== 32'h79) begin
      n_fail++;
      $display("FAIL mis_redirect: valid=%b imem_pc=%h, expected 0/79", fq.out_valid, fq.imem_pc);
    end
    tick();
    n_tests++;
    if (fq.out_valid !== 1'b1 || fq.out_pc !== 32'h79 || fq.out_instruction !== NOP ||
        fq.out_misaligned !== 1'b1 || fq.count !== 3'd1) begin
      n_fail++;
      $display("FAIL mis_entry: valid=%b pc=%h instr=%h mis=%b count=%0d, expected 1/79/13/1/1",
               fq.out_valid, fq.out_pc, fq.out_instruction, fq.out_misaligned, fq.count);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (fq.out_valid !== 1'b0 || fq.imem_pc !== 32'h79 || fq.count !== 3'd0) begin
        n_fail++;
        $display("FAIL mis_halt[%0d]: valid=%b imem_pc=%h count=%0d, expected 0/79/0",
                 i, fq.out_valid, fq.imem_pc, fq.count);
      end
    end
    fq.redirect = 1'b1; fq.redirect_pc = 32'h1000;
    tick();
    fq.redirect = 1'b0;
    tick(); tick();
    n_tests++;
    if (fq.out_valid !== 1'b1 || fq.out_pc !== 32'h1004 || fq.out_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_resume: valid=%b pc=%h mis=%b, expected 1/1004/0", fq.out_valid, fq.out_pc, fq.out_misaligned);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    fq.out_ready = 1'b1;
    fq.redirect = 1'b1; fq.redirect_pc = 32'hFFFF_FFF8;
    tick();
    fq.redirect = 1'b0;
    exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (fq.out_valid !== 1'b1 || fq.out_pc !== exp_pc) begin
        n_fail++;
        $display("FAIL wrap[%0d]: valid=%b pc=%h, expected 1/%h", i, fq.out_valid, fq.out_pc, exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_reset_priority();
    fq.out_ready = 1'b1;
    tick(); tick();
    reset_n = 1'b0; fq.redirect = 1'b1; fq.redirect_pc = 32'h2000;
    tick();
    n_tests++;
    if (fq.out_valid !== 1'b0 || fq.count !== 3'd0 || fq.imem_pc !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_priority: valid=%b count=%0d imem_pc=%h, expected 0/0/%h",
               fq.out_valid, fq.count, fq.imem_pc, RESET_PC);
    end
    reset_n = 1'b1; fq.redirect = 1'b0;
    tick();
    n_tests++;
    if (fq.out_valid !== 1'b1 || fq.out_pc !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_priority_release: valid=%b pc=%h, expected 1/%h", fq.out_valid, fq.out_pc, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    bit ok;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      fq.redirect = ($urandom_range(0, 19) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) rpc[31:4] = 28'hFFF_FFFF;
      fq.redirect_pc = rpc;
      fq.out_ready = ($urandom_range(0, 2) != 0);
      tick();
      ok = (fq.imem_pc === m_pc) && (fq.count === 3'(mq.size())) && (fq.out_valid === (mq.size() != 0));
      if (ok && mq.size() != 0)
        ok = (fq.out_pc === mq[0].pc) && (fq.out_instruction === mq[0].instr) && (fq.out_misaligned === mq[0].mis);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL random[%0d]: imem_pc=%h count=%0d valid=%b pc=%h instr=%h mis=%b, expected imem_pc=%h count=%0d head=%h/%h/%b",
                 i, fq.imem_pc, fq.count, fq.out_valid, fq.out_pc, fq.out_instruction, fq.out_misaligned,
                 m_pc, mq.size(), (mq.size() != 0) ? mq[0].pc : 32'h0,
                 (mq.size() != 0) ? mq[0].instr : 32'h0, (mq.size() != 0) ? mq[0].mis : 1'b0);
      end
    end
  endtask

  initial begin
    fq.redirect = 1'b0; fq.redirect_pc = '0; fq.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_misaligned();
    test_wrap();
    test_reset_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
